spio_4: RTL and testbench
=========================

// Module: spio_4
// PURPOSE
//   Serial-in/parallel-out shift register, default 4 bits wide.
//   Captures one serial bit per rising clock edge into an LSB-first shift chain.
//   Presents the whole chain as a parallel word.
//   Sits between a single-bit serial source and any parallel consumer; no handshake upstream.
// PARAMETERS
//   WIDTH      4   number of stages / width of q (legal range 2..32)
//   SHIFT_LEFT 1   1: new bit enters q[0] and data moves toward q[WIDTH-1];
//                  0: new bit enters q[WIDTH-1] and data moves toward q[0]
// PORTS
//   clk     in   1      sole clock; all state updates on the rising edge
//   clear   in   1      reset: asynchronous, active-low; clear=0 forces all state to reset values
//   datain  in   1      serial data bit, sampled on each rising clk edge while clear=1
//   q       out  WIDTH  parallel register contents, driven directly from flops
//   q_valid out  1      present only with SPIO_4_VALID_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: clear=0 -> q=0 immediately, with no clock required (q_valid=0, bit counter=0).
//     Reset holds for as long as clear stays low; datain is ignored during reset.
//   - Release: the first shift happens on the first rising clk edge with clear=1.
//     Deassertion concurrent with an edge: that edge does not shift.
//   - Shift with SHIFT_LEFT=1: q <= {q[WIDTH-2:0], datain} every rising edge, unconditionally (no enable).
//   - Shift with SHIFT_LEFT=0: q <= {datain, q[WIDTH-1:1]}.
//   - Latency: a bit sampled at edge n appears at the entry stage after edge n.
//     It reaches the far stage after WIDTH-1 further edges.
//     It is discarded at the following edge; no wrap-around or recirculation.
//   - Mid-operation reset: clear falling at any time zeroes q asynchronously; the shift history is lost.
//   - No X propagation from reset: every flop has an explicit async reset value of 0.
//   - Pure register block: no combinational path from datain to q.
// CONFIGURATION
//   SPIO_4_VALID_EN defined:
//     - Adds output q_valid plus an internal saturating counter of $clog2(WIDTH+1) bits.
//     - Counter increments on each shift edge after release and saturates at WIDTH.
//     - q_valid=1 once the counter equals WIDTH, meaning every stage holds post-reset data.
//     - q_valid stays 1 until the next reset; clear=0 clears the counter and q_valid asynchronously.
//   SPIO_4_VALID_EN undefined:
//     - Neither the port nor the counter exists.
//     - Port list is exactly clk, clear, datain, q.
// TESTING (WIDTH=4, SHIFT_LEFT=1, 10 ns clock, rising edges at 5,15,25,...)
//   1. clear=0 for 30 ns while datain toggles -> q=4'b0000 throughout; q_valid=0.
//   2. Release at 30 ns, datain 0@35, 1@45, 0@55, 1@65 ->
//      q=0000, 0001, 0010, 0101 after the respective edges.
//   3. After scenario 2, datain=1 for 4 edges -> q=1011, 0111, 1111, 1111;
//      q_valid goes 1 at the 4th post-release edge.
//   4. q=4'b1111, then drive clear=0 between edges -> q=0000 before the next edge;
//      q_valid=0 before the next edge (async check).
//   5. SHIFT_LEFT=0, shift in 1,0,0,0 -> q=1000, 0100, 0010, 0001; a 5th edge with datain=0 -> 0000.
//   6. Build twice, with and without SPIO_4_VALID_EN -> port list and q sequences match scenario 2 in both builds.

Source files
------------

// File: rtl/spio_4.sv
// -----------------------------------------------------------------------------
// spio_4 : serial-in / parallel-out shift register
//
// One serial bit is captured on every rising clk edge into a WIDTH-stage shift
// chain; the whole chain is presented as a parallel word straight from flops.
//
// Parameters
//   WIDTH      : number of stages / width of q (2..32)
//   SHIFT_LEFT : 1 -> new bit enters q[0], data moves toward q[WIDTH-1]
//                0 -> new bit enters q[WIDTH-1], data moves toward q[0]
//
// Ports
//   clk     : clock, rising edge
//   clear   : asynchronous active-low reset, zeroes all state
//   datain  : serial data bit
//   q       : parallel shift-chain contents
//   q_valid : every stage holds post-reset data (only with SPIO_4_VALID_EN)
//
// Build option
//   SPIO_4_VALID_EN : adds q_valid and its saturating fill counter.
// -----------------------------------------------------------------------------
module spio_4 #(
  parameter int WIDTH      = 4,
  parameter int SHIFT_LEFT = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             datain,
  output logic [WIDTH-1:0] q
`ifdef SPIO_4_VALID_EN
  ,
  output logic             q_valid
`endif
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (SHIFT_LEFT != 0) begin
      shift_d = {shift_q[WIDTH-2:0], datain};
    end else begin
      shift_d = {datain, shift_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign q = shift_q;

`ifdef SPIO_4_VALID_EN
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counts shifts since reset; stops at WIDTH once the chain is fully refilled.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != CNT_FULL) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_valid = (cnt_q == CNT_FULL);
`endif

endmodule

// File: tb/tb_spio_4.sv
// -----------------------------------------------------------------------------
// tb_spio_4 : self-checking bench for spio_4 (WIDTH=4), both shift directions.
// A history-of-bits reference model predicts q and q_valid.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spio_4;

  localparam int W = 4;

  logic         clk;
  logic         clear;
  logic         datain;
  logic [W-1:0] q_l;
  logic [W-1:0] q_r;
`ifdef SPIO_4_VALID_EN
  logic         v_l;
  logic         v_r;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: bits shifted in since the last reset, newest first.
  bit hist[$];
  int nshift = 0;

  spio_4 #(.WIDTH(W), .SHIFT_LEFT(1)) dut_l (
    .clk    (clk),
    .clear  (clear),
    .datain (datain),
    .q      (q_l)
`ifdef SPIO_4_VALID_EN
    ,
    .q_valid(v_l)
`endif
  );

  spio_4 #(.WIDTH(W), .SHIFT_LEFT(0)) dut_r (
    .clk    (clk),
    .clear  (clear),
    .datain (datain),
    .q      (q_r)
`ifdef SPIO_4_VALID_EN
    ,
    .q_valid(v_r)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_q(input bit left);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < hist.size(); i++) begin
      if (left) r[i] = hist[i];
      else      r[W-1-i] = hist[i];
    end
    return r;
  endfunction

  function automatic void model_shift(input bit d);
    hist.push_front(d);
    if (hist.size() > W) void'(hist.pop_back());
    nshift++;
  endfunction

  function automatic void model_reset();
    hist.delete();
    nshift = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_qL"}, 32'(q_l), 32'(model_q(1'b1)));
    chk({tag, "_qR"}, 32'(q_r), 32'(model_q(1'b0)));
`ifdef SPIO_4_VALID_EN
    chk({tag, "_vL"}, 32'(v_l), 32'(nshift >= W));
    chk({tag, "_vR"}, 32'(v_r), 32'(nshift >= W));
`endif
  endtask

  // Entered in the low clock phase; drives one bit, checks after the edge,
  // returns at the following falling edge.
  task automatic step(input bit d, input string tag);
    datain = d;
    @(posedge clk);
    #1;
    model_shift(d);
    check_all(tag);
    @(negedge clk);
  endtask

  // Entered at a falling edge; asserts clear between edges and checks that
  // the outputs drop without any clock, then releases in the low phase.
  task automatic do_reset(input string tag);
    clear  = 1'b0;
    datain = 1'($urandom);
    #1;
    model_reset();
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    @(negedge clk);
    clear = 1'b1;
  endtask

  initial begin
    clear  = 1'b0;
    datain = 1'b0;

    // Reset held for three edges while datain toggles.
    for (int i = 0; i < 3; i++) begin
      datain = ~datain;
      @(posedge clk);
      #1;
      check_all("rst_hold");
      chk("rst_hold_const", 32'(q_l), 32'h0);
    end
    @(negedge clk);
    clear = 1'b1;

    // Directed sequence after release.
    step(1'b0, "s2a"); chk("s2a_const", 32'(q_l), 32'h0);
    step(1'b1, "s2b"); chk("s2b_const", 32'(q_l), 32'h1);
    step(1'b0, "s2c"); chk("s2c_const", 32'(q_l), 32'h2);
    step(1'b1, "s2d"); chk("s2d_const", 32'(q_l), 32'h5);
    step(1'b1, "s3a"); chk("s3a_const", 32'(q_l), 32'hB);
    step(1'b1, "s3b"); chk("s3b_const", 32'(q_l), 32'h7);
    step(1'b1, "s3c"); chk("s3c_const", 32'(q_l), 32'hF);
    step(1'b1, "s3d"); chk("s3d_const", 32'(q_l), 32'hF);
`ifdef SPIO_4_VALID_EN
    chk("s3_valid_const", 32'(v_l), 32'h1);
`endif

    // Asynchronous clear between edges.
    do_reset("s4");
    chk("s4_const", 32'(q_l), 32'h0);

    // Right-shifting instance: walking one toward q[0], then falls off.
    step(1'b1, "s5a"); chk("s5a_const", 32'(q_r), 32'h8);
    step(1'b0, "s5b"); chk("s5b_const", 32'(q_r), 32'h4);
    step(1'b0, "s5c"); chk("s5c_const", 32'(q_r), 32'h2);
    step(1'b0, "s5d"); chk("s5d_const", 32'(q_r), 32'h1);
    step(1'b0, "s5e"); chk("s5e_const", 32'(q_r), 32'h0);

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step(1'($urandom), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
